alu_exec_unit: RTL and testbench

- Execute-stage consumer of the ALU control word: ALU[3:0], InvA, InvB, cin.
- Takes two WIDTH-bit operands plus that control word through a valid/ready handshake and produces a registered result and flags.
- Single-cycle ops finish in one cycle; shifts and rotates run on an iterative one-bit-per-cycle shifter.
- Sits between decode/register-read and writeback in the single-cycle-derived multicycle datapath.

---
 rtl/alu_exec_pkg.sv | 31 +++
 rtl/alu_comb_core.sv | 77 +++++++
 rtl/alu_exec_unit.sv | 124 ++++++++++++
 tb/tb_alu_exec_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared op codes, FSM encoding and helpers for the ALU execute unit.
package alu_exec_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] ALU_ROL  = 4'b0000;
    localparam logic [3:0] ALU_ROR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_PASS = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_BTR  = 4'b1011;
    localparam logic [3:0] ALU_SEQ  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLE  = 4'b1110;
    localparam logic [3:0] ALU_SCO  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Shift and rotate ops occupy the 00xx corner of the op space.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: operand conditioning, adder, logic/set ops and flags.
// Shift ops pass a through unchanged; that is the amount-zero result.
module alu_comb_core
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       alu_op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    logic [WIDTH-1:0] a_c;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sum_raw;
    logic             add_ovf;
    logic [WIDTH-1:0] a_rev;

    assign a_c     = inv_a ? ~a : a;
    assign b_c     = inv_b ? ~b : b;
    assign sum     = {1'b0, a_c} + {1'b0, b_c} + {{WIDTH{1'b0}}, cin};
    assign sum_raw = {1'b0, a} + {1'b0, b};
    assign add_ovf = (a_c[WIDTH-1] == b_c[WIDTH-1]) && (sum[WIDTH-1] != a_c[WIDTH-1]);
    assign zero    = (result == '0);

    // Bit-reversal of the raw operand for BTR.
    always_comb begin
        a_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            a_rev[i] = a[WIDTH-1-i];
        end
    end

    // Op decode; set-type results are zero-extended, unknown codes flag err.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (alu_op)
            ALU_ROL, ALU_ROR, ALU_SLL, ALU_SRL: result = a;
            ALU_ADD: begin
                result = sum[WIDTH-1:0];
                ovf    = add_ovf;
            end
            ALU_AND:  result = a_c & b_c;
            ALU_PASS: result = a_c;
            ALU_XOR:  result = a_c ^ b_c;
            ALU_BTR:  result = a_rev;
            ALU_SEQ: begin
                result = {{(WIDTH-1){1'b0}}, (sum[WIDTH-1:0] == '0)};
                ovf    = add_ovf;
            end
            ALU_SLT: begin
                result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                ovf    = add_ovf;
            end
            ALU_SLE: begin
                result = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
                ovf    = add_ovf;
            end
            ALU_SCO: begin
                result = {{(WIDTH-1){1'b0}}, sum_raw[WIDTH]};
                ovf    = add_ovf;
            end
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready in, registered result/flags out.
// Non-shift ops complete in one cycle; shifts/rotates step one bit per cycle.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ovf_q;
    logic               err_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [1:0]         sop_q;
    logic [WIDTH-1:0]   shift_d;
    logic [SHAMT_W-1:0] amt;

    logic [WIDTH-1:0]   core_result;
    logic               core_zero;
    logic               core_ovf;
    logic               core_err;

    assign amt       = b[SHAMT_W-1:0];
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .alu_op (alu_op),
        .inv_a  (inv_a),
        .inv_b  (inv_b),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .result (core_result),
        .zero   (core_zero),
        .ovf    (core_ovf),
        .err    (core_err)
    );

    // One-bit step of the serial shifter for the latched shift op.
    always_comb begin
        case (sop_q)
            2'b00:   shift_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            2'b01:   shift_d = {result_q[0], result_q[WIDTH-1:1]};
            2'b10:   shift_d = {result_q[WIDTH-2:0], 1'b0};
            default: shift_d = {1'b0, result_q[WIDTH-1:1]};
        endcase
    end

    // Control FSM with registered result and flags; result_q doubles as shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            sop_q    <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_shift_op(alu_op) && (amt != '0)) begin
                            result_q <= a;
                            cnt_q    <= amt;
                            sop_q    <= alu_op[1:0];
                            zero_q   <= 1'b0;
                            ovf_q    <= 1'b0;
                            err_q    <= 1'b0;
                            state_q  <= ST_SHIFT;
                        end else begin
                            result_q <= core_result;
                            zero_q   <= core_zero;
                            ovf_q    <= core_ovf;
                            err_q    <= core_err;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= shift_d;
                    cnt_q    <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        zero_q  <= (shift_d == '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        inv_a;
    logic        inv_b;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        ovf;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .inv_a     (inv_a),
        .inv_b     (inv_b),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic void model(input logic [3:0] op, input logic ia, input logic ib,
                                  input logic ci, input logic [15:0] av, input logic [15:0] bv,
                                  output logic [15:0] r, output logic z, output logic o,
                                  output logic e, output int lat);
        logic [15:0] ap_v;
        logic [15:0] bp_v;
        int ua, ub, ap, bp, sap, sbp, sa, sb, k, s, rr;
        ap_v = ia ? ~av : av;
        bp_v = ib ? ~bv : bv;
        ua = int'(av); ub = int'(bv);
        ap = int'(ap_v); bp = int'(bp_v);
        sap = $signed(ap_v); sbp = $signed(bp_v);
        sa = $signed(av); sb = $signed(bv);
        k = int'(bv[3:0]);
        s = sap + sbp + int'(ci);
        rr = 0; o = 1'b0; e = 1'b0;
        case (op)
            4'd0:  rr = (ua << k) | (ua >> (16 - k));
            4'd1:  rr = (ua >> k) | (ua << (16 - k));
            4'd2:  rr = ua << k;
            4'd3:  rr = ua >> k;
            4'd4:  rr = ap + bp + int'(ci);
            4'd5:  rr = ap & bp;
            4'd6:  rr = ap;
            4'd7:  rr = ap ^ bp;
            4'd11: for (int i = 0; i < 16; i++) if (av[i]) rr = rr + (1 << (15 - i));
            4'd12: rr = (((ap + bp + int'(ci)) % 65536) == 0) ? 1 : 0;
            4'd13: rr = (sa < sb) ? 1 : 0;
            4'd14: rr = (sa <= sb) ? 1 : 0;
            4'd15: rr = (ua + ub) / 65536;
            default: begin rr = 0; e = 1'b1; end
        endcase
        if (op == 4'd4 || op >= 4'd12) o = (s > 32767) || (s < -32768);
        r = 16'(rr & 32'hFFFF);
        z = (r == 16'h0000);
        lat = (op < 4'd4 && k != 0) ? 1 + k : 1;
    endfunction

    // Issue one op, measure latency, check outputs, hold under backpressure, release.
    task automatic run_op(input string tag, input logic [3:0] op, input logic ia, input logic ib,
                          input logic ci, input logic [15:0] av, input logic [15:0] bv,
                          input int hold, input bit poke);
        logic [15:0] er;
        logic ez, eo, ee;
        int elat, lat;
        bit busy_bad, hold_bad;
        model(op, ia, ib, ci, av, bv, er, ez, eo, ee, elat);
        alu_op = op; inv_a = ia; inv_b = ib; cin = ci; a = av; b = bv;
        in_valid = 1'b1;
        check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_bad = 1'b1;
            in_valid = poke;
            if (poke) begin
                a = 16'($urandom);
                alu_op = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check_val({tag, ".lat"}, 32'(lat), 32'(elat));
        check_val({tag, ".result"}, 32'(result), 32'(er));
        check_val({tag, ".zero"}, 32'(zero), 32'(ez));
        check_val({tag, ".ovf"}, 32'(ovf), 32'(eo));
        check_val({tag, ".err"}, 32'(err), 32'(ee));
        if (elat > 1) check_val({tag, ".busy_ready"}, 32'(busy_bad), 32'd0);
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || result !== er || zero !== ez || ovf !== eo || err !== ee)
                hold_bad = 1'b1;
        end
        if (hold > 0) check_val({tag, ".hold"}, 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, ".release"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  r_op;
        logic [15:0] r_a, r_b;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 4'd0; inv_a = 1'b0; inv_b = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.outs", {12'd0, result, zero, ovf, err, out_valid}, 32'd0);
        check_val("reset.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_ovf",  4'b0100, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 0, 1'b0);
        run_op("seq_eq",   4'b1100, 1'b1, 1'b0, 1'b1, 16'd5,    16'd5,    0, 1'b0);
        run_op("seq_ne",   4'b1100, 1'b1, 1'b0, 1'b1, 16'd3,    16'd5,    0, 1'b0);
        run_op("rol4",     4'b0000, 1'b0, 1'b0, 1'b0, 16'h8001, 16'd4,    0, 1'b0);
        run_op("ror0",     4'b0001, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0010, 0, 1'b0);
        run_op("srl15",    4'b0011, 1'b0, 1'b0, 1'b0, 16'hF000, 16'd15,   0, 1'b1);
        run_op("sll15",    4'b0010, 1'b0, 1'b0, 1'b0, 16'h0003, 16'd15,   0, 1'b0);
        run_op("andn_bp",  4'b0101, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h00FF, 10, 1'b0);
        run_op("btr",      4'b1011, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 0, 1'b0);
        run_op("slt_neg",  4'b1101, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 0, 1'b0);
        run_op("sle_eq",   4'b1110, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h8000, 0, 1'b0);
        run_op("sco",      4'b1111, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 0, 1'b0);

        // Reset in the middle of a long shift, then an unsupported op.
        alu_op = 4'b0011; inv_a = 1'b0; inv_b = 1'b0; cin = 1'b0;
        a = 16'hF000; b = 16'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midreset.outs", {12'd0, result, zero, ovf, err, out_valid}, 32'd0);
        check_val("midreset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("illegal9", 4'b1001, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            r_op = 4'($urandom);
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            run_op("rand", r_op, 1'($urandom), 1'($urandom), 1'($urandom), r_a, r_b,
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
